mem_stage_data_responder: RTL and testbench

- Data-memory responder for the MEM stage of the 5-stage ARM pipeline.
- Accepts single-word load/store requests driven by the MEM stage and models an SRAM with a programmable number of wait states.
- Drives ready low while an access is in flight; the top level uses it as the pipeline freeze source.
- Holds the word-addressed data array and returns load data to the MEM/WB pipe register.

---
 rtl/mem_stage_data_responder_pkg.sv | 14 +
 rtl/mem_stage_data_responder_data_mem_array.sv | 23 ++
 rtl/mem_stage_data_responder.sv | 108 ++++++++++
 tb/tb_mem_stage_data_responder.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mem_stage_data_responder_pkg.sv
// Shared MEM-stage definitions: responder state encoding, datapath width and
// the default byte address of data-memory word 0.
package mem_stage_data_responder_pkg;

  localparam int DATA_W = 32;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_stage_data_responder_data_mem_array.sv
// Single-port 2^ADDR_W x 32 data RAM with synchronous write and a
// read-enabled synchronous read register that holds between reads.
module data_mem_array
  import mem_stage_data_responder_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_stage_data_responder.sv
// MEM-stage data responder: SRAM model with programmable wait states, range
// checking and a one-cycle DONE handshake that doubles as the pipeline freeze.
module mem_stage_data_responder
  import mem_stage_data_responder_pkg::*;
#(
  parameter int          ADDR_W      = 6,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          WAIT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err
);

  localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  state_t            state, state_nx;
  logic [3:0]        cnt;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              store_q, conflict_q;
  logic              err_q, rdata_zero;

  logic              req, commit;
  logic [31:0]       cur_addr, offset;
  logic [DATA_W-1:0] cur_wdata;
  logic              cur_store, cur_conflict, oor;
  logic [ADDR_W-1:0] idx;
  logic              ram_we, ram_re;
  logic [DATA_W-1:0] ram_q;

  assign req = mem_r_en | mem_w_en;

  // In IDLE the live request is used so a zero-wait access can commit at once;
  // afterwards only the latched copy matters.
  assign cur_addr     = (state == IDLE) ? addr : addr_q;
  assign cur_wdata    = (state == IDLE) ? wdata : wdata_q;
  assign cur_store    = (state == IDLE) ? mem_w_en : store_q;
  assign cur_conflict = (state == IDLE) ? (mem_r_en & mem_w_en) : conflict_q;

  assign offset = cur_addr - BASE_ADDR;
  assign oor    = (cur_addr < BASE_ADDR) || ((offset >> (ADDR_W + 2)) != 32'd0);
  assign idx    = offset[ADDR_W+1:2];

  assign commit = req && (((state == IDLE) && (WAIT_CYCLES == 0)) ||
                          ((state == ACCESS) && (cnt == 4'd0)));

  assign ram_we = commit & cur_store & ~oor;
  assign ram_re = commit & ~cur_store & ~oor;

  data_mem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (idx),
    .wdata (cur_wdata),
    .rdata (ram_q)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = (WAIT_CYCLES == 0) ? DONE : ACCESS;
      ACCESS:  if (!req) state_nx = IDLE;
               else if (cnt == 4'd0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      store_q    <= 1'b0;
      conflict_q <= 1'b0;
      err_q      <= 1'b0;
      rdata_zero <= 1'b1;
    end else begin
      state <= state_nx;
      err_q <= commit & (oor | cur_conflict);
      if (state == IDLE && req) begin
        cnt        <= CNT_INIT;
        addr_q     <= addr;
        wdata_q    <= wdata;
        store_q    <= mem_w_en;
        conflict_q <= mem_r_en & mem_w_en;
      end else if (state == ACCESS && req && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // Out-of-range loads read as zero without disturbing the RAM register.
      if (commit && !cur_store) rdata_zero <= oor;
    end
  end

  assign rdata = rdata_zero ? '0 : ram_q;
  assign ready = ((state == IDLE) && !req) || (state == DONE);
  assign err   = err_q;

endmodule

// File: tb/tb_mem_stage_data_responder.sv
// Directed bench for mem_stage_data_responder: a 3-wait-state instance driven
// from a vector table plus corner sequences, and a zero-wait instance.
module tb_mem_stage_data_responder;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic        r_en  [2];
  logic        w_en  [2];
  logic [31:0] a     [2];
  logic [31:0] wd    [2];
  logic [31:0] rd    [2];
  logic        rdy   [2];
  logic        er    [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage_data_responder #(.ADDR_W(6), .BASE_ADDR(32'd1024), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst[0]), .mem_r_en(r_en[0]), .mem_w_en(w_en[0]),
    .addr(a[0]), .wdata(wd[0]), .rdata(rd[0]), .ready(rdy[0]), .err(er[0])
  );

  mem_stage_data_responder #(.ADDR_W(6), .BASE_ADDR(32'd1024), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst[1]), .mem_r_en(r_en[1]), .mem_w_en(w_en[1]),
    .addr(a[1]), .wdata(wd[1]), .rdata(rd[1]), .ready(rdy[1]), .err(er[1])
  );

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full handshake: request, wait for ready (bounded), check DONE outputs, release.
  task automatic access(input int d, input logic r, input logic w, input logic [31:0] ad,
                        input logic [31:0] dat, input logic [31:0] exp_rd, input logic exp_err,
                        input int lat, input string name);
    int n;
    r_en[d] = r; w_en[d] = w; a[d] = ad; wd[d] = dat;
    #1;
    chk({name, " ready_cycle0"}, 32'(rdy[d]), 32'd0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!rdy[d] && n < 20);
    chk({name, " latency"}, n, lat);
    chk({name, " rdata"}, rd[d], exp_rd);
    chk({name, " err"}, 32'(er[d]), 32'(exp_err));
    r_en[d] = 1'b0; w_en[d] = 1'b0;
    tick();
    chk({name, " err_cleared"}, 32'(er[d]), 32'd0);
    chk({name, " ready_idle"}, 32'(rdy[d]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 1'b1, 32'd1036, 32'h11111111, 32'h0,        1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'd1040, 32'h00000077, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'd1020, 32'h0,        32'h0,        1'b1};
    vecs[5]  = '{1'b0, 1'b1, 32'd1280, 32'hCAFEF00D, 32'h0,        1'b1};
    vecs[6]  = '{1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5, 32'h0,        1'b1};
    vecs[7]  = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'hA5A5A5A5, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'd1276, 32'h0BADC0DE, 32'hDEADBEEF, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'd1276, 32'h0,        32'h0BADC0DE, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF, 1'b0};

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; r_en[d] = 1'b0; w_en[d] = 1'b0; a[d] = '0; wd[d] = '0;
    end
    tick();
    tick();
    rst[0] = 1'b0; rst[1] = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset%0d ready", d), 32'(rdy[d]), 32'd1);
      chk($sformatf("reset%0d rdata", d), rd[d], 32'd0);
      chk($sformatf("reset%0d err", d), 32'(er[d]), 32'd0);
    end
    tick();

    for (int i = 0; i < 12; i++)
      access(0, vecs[i].r, vecs[i].w, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_err, 4, $sformatf("vec%0d", i));

    // Reset in the middle of a pending store.
    w_en[0] = 1'b1; a[0] = 32'd1036; wd[0] = 32'h22222222;
    tick();
    tick();
    chk("rst_mid ready_access", 32'(rdy[0]), 32'd0);
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0; w_en[0] = 1'b0;
    #1;
    chk("rst_mid ready", 32'(rdy[0]), 32'd1);
    chk("rst_mid rdata", rd[0], 32'd0);
    chk("rst_mid err", 32'(er[0]), 32'd0);
    tick();
    access(0, 1'b1, 1'b0, 32'd1036, 32'h0, 32'h11111111, 1'b0, 4, "rst_mid reload");

    // Store abandoned after one ACCESS cycle.
    w_en[0] = 1'b1; a[0] = 32'd1040; wd[0] = 32'h00000001;
    tick();
    w_en[0] = 1'b0;
    #1;
    chk("abort ready_access", 32'(rdy[0]), 32'd0);
    tick();
    chk("abort ready_idle", 32'(rdy[0]), 32'd1);
    chk("abort err", 32'(er[0]), 32'd0);
    tick();
    chk("abort err_later", 32'(er[0]), 32'd0);
    access(0, 1'b1, 1'b0, 32'd1040, 32'h0, 32'h00000077, 1'b0, 4, "abort reload");

    // Zero-wait-state instance.
    access(1, 1'b0, 1'b1, 32'd1028, 32'h12345678, 32'h0,        1'b0, 1, "w0 store");
    access(1, 1'b1, 1'b0, 32'd1028, 32'h0,        32'h12345678, 1'b0, 1, "w0 load");
    access(1, 1'b1, 1'b0, 32'd1020, 32'h0,        32'h0,        1'b1, 1, "w0 oor");
    access(1, 1'b1, 1'b0, 32'd1028, 32'h0,        32'h12345678, 1'b0, 1, "w0 reload");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
